// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART controller slice.
// Optional feature macro used by this slice: UART_CTRL_TIMEOUT_EN.
package uart_pkg;

    // Transmit launch FSM states; encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    // Number of txclken ticks WAIT_BUSY tolerates before giving up.
    localparam int TX_TIMEOUT_TICKS = 4;

    // System clocks per receiver oversampling tick, truncated.
    function automatic int rx_div_f(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divides the system clock into the receiver's oversampling
// enable (rxclken) and the transmitter's bit enable (txclken). Both are
// registered one-cycle pulses; txclken coincides with every OVERSAMPLE-th
// rxclken.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 18_432_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic rxclken,
    output logic txclken
);

    localparam int RX_DIV = rx_div_f(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W  = (RX_DIV > 2) ? $clog2(RX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RX_DIV - 1);
    localparam logic [3:0]       SUB_MAX = 4'(OVERSAMPLE - 1);

    // A divider below 2 cannot produce distinct enable pulses.
    generate
        if (RX_DIV < 2) begin : g_bad_div
            $error("uart_baud_gen: RX_DIV must be >= 2");
        end
        if (OVERSAMPLE < 1 || OVERSAMPLE > 16) begin : g_bad_os
            $error("uart_baud_gen: OVERSAMPLE must fit the 4-bit sub-counter");
        end
    endgenerate

    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_sub_cnt;
    logic             r_rxclken;
    logic             r_txclken;
    logic             w_div_wrap;

    assign w_div_wrap = (r_div_cnt == DIV_MAX);

    // Divider and sub-counter; enables are registered from the wrap condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_sub_cnt <= '0;
            r_rxclken <= 1'b0;
            r_txclken <= 1'b0;
        end else begin
            r_rxclken <= w_div_wrap;
            r_txclken <= w_div_wrap && (r_sub_cnt == SUB_MAX);
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_sub_cnt <= (r_sub_cnt == SUB_MAX) ? 4'd0 : r_sub_cnt + 4'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign rxclken = r_rxclken;
    assign txclken = r_txclken;

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: baud enables, round-robin arbitration of two byte requesters
// onto one transmitter, and a one-byte receive buffer with overrun flag.
// Optional feature macro: UART_CTRL_TIMEOUT_EN (launch timeout in WAIT_BUSY,
// reported on tx_err). Without it WAIT_BUSY waits forever and tx_err is 0.
//
// Handshakes: a requester holds req until it sees its one-cycle gnt and
// drops req in that gnt cycle; gnt and tx_start share the cycle after the
// accepting edge. The receive side presents a byte on dout while rdy is 1;
// the consumer pulses rdy_clr once it has taken it.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 18_432_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rxclken,
    output logic       txclken,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       tx_err,
    input  logic       rx_done,
    input  logic [7:0] rx_dout,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    uart_baud_gen #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .rxclken(rxclken),
        .txclken(txclken)
    );

    tx_state_t  r_state;
    logic       r_last;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic       w_pick1;
`ifdef UART_CTRL_TIMEOUT_EN
    logic [2:0] r_to_cnt;
    logic       r_tx_err;
`endif

    // Requester 1 wins when it is alone, or on a tie when 0 won last time.
    assign w_pick1 = req1 && (!req0 || !r_last);

    // Transmit launch FSM with registered grant/start/error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
`ifdef UART_CTRL_TIMEOUT_EN
            r_to_cnt   <= 3'd0;
            r_tx_err   <= 1'b0;
`endif
        end else begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_tx_start <= 1'b0;
`ifdef UART_CTRL_TIMEOUT_EN
            r_tx_err   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if ((req0 || req1) && !tx_busy) begin
                        r_tx_data  <= w_pick1 ? data1 : data0;
                        r_gnt0     <= !w_pick1;
                        r_gnt1     <= w_pick1;
                        r_tx_start <= 1'b1;
                        r_last     <= w_pick1;
                        r_state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
`ifdef UART_CTRL_TIMEOUT_EN
                    r_to_cnt <= 3'd0;
`endif
                    r_state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
`ifdef UART_CTRL_TIMEOUT_EN
                    else if (txclken) begin
                        if (r_to_cnt == 3'(TX_TIMEOUT_TICKS - 1)) begin
                            r_tx_err <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 3'd1;
                        end
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign dbg_state = r_state;
`ifdef UART_CTRL_TIMEOUT_EN
    assign tx_err    = r_tx_err;
`else
    assign tx_err    = 1'b0;
`endif

    logic       r_rdy;
    logic       r_overrun;
    logic [7:0] r_dout;

    // One-byte receive buffer; a byte arriving while full is dropped unless
    // the consumer clears in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy     <= 1'b0;
            r_overrun <= 1'b0;
            r_dout    <= 8'h00;
        end else if (rx_done) begin
            if (!r_rdy || rdy_clr) begin
                r_dout <= rx_dout;
                r_rdy  <= 1'b1;
                if (rdy_clr) begin
                    r_overrun <= 1'b0;
                end
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (rdy_clr) begin
            r_rdy     <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign rdy     = r_rdy;
    assign overrun = r_overrun;
    assign dout    = r_dout;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl with default parameters
// (RX_DIV = 10). Launches are checked against a queue of expected
// {gnt1, gnt0, tx_data} entries filled when requests are driven.
module tb_uart_ctrl;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic       rxclken;
    logic       txclken;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_err;
    logic       rx_done;
    logic [7:0] rx_dout;
    logic       rdy;
    logic       rdy_clr;
    logic [7:0] dout;
    logic       overrun;
    logic [1:0] dbg_state;

    uart_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .rxclken  (rxclken),
        .txclken  (txclken),
        .req0     (req0),
        .req1     (req1),
        .data0    (data0),
        .data1    (data1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_err   (tx_err),
        .rx_done  (rx_done),
        .rx_dout  (rx_dout),
        .rdy      (rdy),
        .rdy_clr  (rdy_clr),
        .dout     (dout),
        .overrun  (overrun),
        .dbg_state(dbg_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_err_pulses = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  mon_exp;
    logic [31:0] w_all_out;

    assign w_all_out = {6'd0, rxclken, txclken, gnt0, gnt1, tx_start, tx_err,
                        rdy, overrun, dout, tx_data, dbg_state};

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch monitor: every grant/start cycle must match the next expected entry
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_err) n_err_pulses++;
            if (tx_start || gnt0 || gnt1) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_launch", {21'd0, tx_start, gnt1, gnt0, tx_data}, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_eq("launch", {21'd0, tx_start, gnt1, gnt0, tx_data},
                             {21'd0, 1'b1, mon_exp});
                end
            end
        end
    end

    // Wait (bounded) for the launch cycle; n = negedges waited.
    task automatic wait_launch(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 20);
        check_eq("launch_seen", tx_start, 1);
    endtask

    // Transmitter model: busy rises one cycle after launch and holds len cycles.
    task automatic run_busy(input int len);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (len) @(negedge clk);
        tx_busy = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic clr);
        rx_dout = b;
        rx_done = 1'b1;
        rdy_clr = clr;
        @(negedge clk);
        rx_done = 1'b0;
        rdy_clr = 1'b0;
    endtask

    task automatic rx_clear();
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
    endtask

    initial begin
        int n;
        int cyc;
        int nticks;
        logic [7:0] rb;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        tx_busy = 1'b0; rx_done = 1'b0; rx_dout = 8'h00; rdy_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", w_all_out, 32'd0);
        rst = 1'b0;

        // Baud enables: rxclken every 10 cycles, txclken every 160
        for (int k = 1; k <= 330; k++) begin
            @(negedge clk);
            check_eq("rxclken", rxclken, (k % 10 == 0));
            check_eq("txclken", txclken, (k % 160 == 0));
        end

        // Round robin with both requesters held: 0,1,0,1
        data0 = 8'hC3; data1 = 8'h3C;
        for (int f = 0; f < 4; f++) begin
            exp_q.push_back((f % 2 == 0) ? {2'b01, 8'hC3} : {2'b10, 8'h3C});
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_launch(n);
            if (f == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            run_busy(20);
        end
        @(negedge clk);
        check_eq("rr_back_idle", dbg_state, ST_IDLE);

        // Single request latency and frame completion
        data0 = 8'hA5;
        exp_q.push_back({2'b01, 8'hA5});
        req0 = 1'b1;
        wait_launch(n);
        req0 = 1'b0;
        check_eq("gnt_latency", n, 1);
        run_busy(50);
        check_eq("tx_data_stable", tx_data, 8'hA5);
        @(negedge clk);
        check_eq("single_back_idle", dbg_state, ST_IDLE);

        // Request while transmitter busy is held off until busy drops
        tx_busy = 1'b1;
        data1 = 8'h77;
        req1 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("no_gnt_busy", {gnt0, gnt1, tx_start}, 3'b000);
        end
        exp_q.push_back({2'b10, 8'h77});
        tx_busy = 1'b0;
        wait_launch(n);
        req1 = 1'b0;
        check_eq("busy_release_latency", n, 1);
        run_busy(5);
        @(negedge clk);
        check_eq("busy_back_idle", dbg_state, ST_IDLE);

        // Receive buffer
        rb = 8'h5A;
        rx_byte(rb, 1'b0);
        check_eq("rx_first", {rdy, overrun, dout}, {1'b1, 1'b0, rb});
        rx_byte(8'h3C, 1'b0);
        check_eq("rx_overrun", {rdy, overrun, dout}, {1'b1, 1'b1, 8'h5A});
        rx_clear();
        check_eq("rx_clear", {rdy, overrun}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            rx_byte(rb, 1'b0);
            check_eq("rx_rand", {rdy, overrun, dout}, {1'b1, 1'b0, rb});
            rx_clear();
        end
        rx_byte(8'h22, 1'b0);
        rx_byte(8'h33, 1'b0);
        check_eq("rx_overrun2", {rdy, overrun, dout}, {1'b1, 1'b1, 8'h22});
        rx_byte(8'h11, 1'b1);
        check_eq("rx_same_cycle_clr", {rdy, overrun, dout}, {1'b1, 1'b0, 8'h11});
        rx_clear();

        // Launch with transmitter never going busy
        data1 = 8'hE7;
        exp_q.push_back({2'b10, 8'hE7});
        req1 = 1'b1;
        wait_launch(n);
        req1 = 1'b0;
`ifdef UART_CTRL_TIMEOUT_EN
        nticks = 0;
        cyc = 0;
        while (!tx_err && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (!tx_err && txclken && dbg_state == ST_WAIT_BUSY) nticks++;
        end
        check_eq("timeout_err", tx_err, 1);
        check_eq("timeout_ticks", nticks, TX_TIMEOUT_TICKS);
        check_eq("timeout_idle", dbg_state, ST_IDLE);
        @(negedge clk);
        check_eq("timeout_err_pulse", tx_err, 0);
        check_eq("timeout_err_count", n_err_pulses, 1);
`else
        nticks = 0;
        for (cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (txclken) nticks++;
        end
        check_eq("no_timeout_ticks_seen", (nticks >= TX_TIMEOUT_TICKS), 1);
        check_eq("no_timeout_state", dbg_state, ST_WAIT_BUSY);
        check_eq("no_timeout_err", n_err_pulses, 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_timeout_idle", dbg_state, ST_IDLE);

        // Reset in WAIT_DONE with a buffered receive byte
        rx_byte(8'h9E, 1'b0);
        check_eq("rx_before_reset", {rdy, dout}, {1'b1, 8'h9E});
        data0 = 8'h4B;
        exp_q.push_back({2'b01, 8'h4B});
        req0 = 1'b1;
        wait_launch(n);
        req0 = 1'b0;
        @(negedge clk);
        tx_busy = 1'b1;
        cyc = 0;
        while (dbg_state != ST_WAIT_DONE && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reached_wait_done", dbg_state, ST_WAIT_DONE);
        rst = 1'b1;
        @(negedge clk);
        check_eq("reset_mid_op", w_all_out, 32'd0);
        rst = 1'b0;
        tx_busy = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("after_reset_idle", {dbg_state, rdy, overrun}, 4'd0);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
